// File: rtl/fwd_hazard_ctrl_if.sv
// ID-stage control bundle between the pipeline (master) and the forwarding/hazard controller (slave).
// The master supplies the advance enable and IFID instruction; the slave returns stall, flush and forward selects.
interface fwd_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             en;
    logic [31:0]      id_ir;
    logic             stall;
    logic             bubble;
    logic             ifid_flush;
    logic [1:0]       fa;
    logic [1:0]       fb;
    logic [CNT_W-1:0] stall_count;
    logic             state_stall;

    modport master (
        output en,
        output id_ir,
        input  stall,
        input  bubble,
        input  ifid_flush,
        input  fa,
        input  fb,
        input  stall_count,
        input  state_stall
    );

    modport slave (
        input  en,
        input  id_ir,
        output stall,
        output bubble,
        output ifid_flush,
        output fa,
        output fb,
        output stall_count,
        output state_stall
    );
endinterface

// File: rtl/fwd_hazard_ctrl.sv
// Forwarding-select and load-use hazard control for a 5-stage MIPS pipeline, using a shadow IDEX/EXMEM/MEMWB dest pipeline.
// stall/bubble/ifid_flush are combinational; fa/fb register on the IDEX edge; en=0 freezes all state and gates stall/flush.
module fwd_hazard_ctrl #(
    parameter logic [5:0] OP_ALU  = 6'd0,
    parameter logic [5:0] OP_JMP  = 6'd2,
    parameter logic [5:0] OP_JAL  = 6'd3,
    parameter logic [5:0] OP_ADDI = 6'd8,
    parameter logic [5:0] OP_LW   = 6'd35,
    parameter logic [5:0] OP_SW   = 6'd43,
    parameter int         CNT_W   = 16
) (
    input  logic             clock,
    input  logic             reset,
    fwd_hazard_ctrl_if.slave hc
);

    typedef struct packed {
        logic       wr;
        logic [4:0] dst;
        logic       ld;
    } shadow_t;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic       unused_ir_bits;

    assign op             = hc.id_ir[31:26];
    assign rs             = hc.id_ir[25:21];
    assign rt             = hc.id_ir[20:16];
    assign rd             = hc.id_ir[15:11];
    assign unused_ir_bits = ^hc.id_ir[10:0];

    shadow_t    idex;
    shadow_t    exmem;
    shadow_t    memwb;
    shadow_t    dec_ent;
    logic       use_rs;
    logic       use_rt;
    logic       is_load;
    logic [4:0] dec_dst;

    logic [1:0]       fa_q;
    logic [1:0]       fb_q;
    logic [1:0]       fa_nxt;
    logic [1:0]       fb_nxt;
    logic [CNT_W-1:0] cnt_q;
    state_t           state;
    state_t           state_nxt;
    logic             load_use;
    logic             stall;
    logic             jump;

    always_comb begin
        dec_dst = 5'd0;
        use_rs  = 1'b0;
        use_rt  = 1'b0;
        is_load = 1'b0;
        case (op)
            OP_ALU: begin
                dec_dst = rd;
                use_rs  = 1'b1;
                use_rt  = 1'b1;
            end
            OP_ADDI: begin
                dec_dst = rt;
                use_rs  = 1'b1;
            end
            OP_LW: begin
                dec_dst = rt;
                use_rs  = 1'b1;
                is_load = 1'b1;
            end
            OP_SW: begin
                use_rs  = 1'b1;
                use_rt  = 1'b1;
            end
            OP_JAL: begin
                dec_dst = 5'd31;
            end
            default: begin
                dec_dst = 5'd0;
            end
        endcase
        // $0 is never written, so it must never match as a producer.
        dec_ent.wr  = (dec_dst != 5'd0);
        dec_ent.dst = dec_dst;
        dec_ent.ld  = is_load && (dec_dst != 5'd0);
    end

    function automatic logic [1:0] fwd_sel(input logic used, input logic [4:0] src,
                                           input shadow_t ex, input shadow_t mem);
        fwd_sel = 2'b00;
        if (used && src != 5'd0) begin
            if (ex.wr && ex.dst == src) begin
                fwd_sel = 2'b10;
            end else if (mem.wr && mem.dst == src) begin
                fwd_sel = 2'b01;
            end
        end
    endfunction

    assign fa_nxt = fwd_sel(use_rs, rs, idex, exmem);
    assign fb_nxt = fwd_sel(use_rt, rt, idex, exmem);

    assign load_use = idex.ld && idex.wr &&
                      ((use_rs && idex.dst == rs) || (use_rt && idex.dst == rt));
    assign jump     = (op == OP_JMP) || (op == OP_JAL);

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        case (state)
            RUN: begin
                stall = hc.en && load_use;
                if (stall) begin
                    state_nxt = STALL;
                end
            end
            STALL: begin
                // The load has reached EXMEM, so one bubble always suffices.
                if (hc.en) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            idex  <= '0;
            exmem <= '0;
            memwb <= '0;
            fa_q  <= 2'b00;
            fb_q  <= 2'b00;
            cnt_q <= '0;
        end else if (hc.en) begin
            memwb <= exmem;
            exmem <= idex;
            idex  <= stall ? '0 : dec_ent;
            fa_q  <= stall ? 2'b00 : fa_nxt;
            fb_q  <= stall ? 2'b00 : fb_nxt;
            if (stall && cnt_q != {CNT_W{1'b1}}) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    // A load marker without a destination would mean the decode let lw $0 through as a producer.
    always_comb begin
        assert (!memwb.ld || memwb.wr);
    end

    assign hc.stall       = stall;
    assign hc.bubble      = stall;
    assign hc.ifid_flush  = hc.en && jump && !stall;
    assign hc.fa          = fa_q;
    assign hc.fb          = fb_q;
    assign hc.stall_count = cnt_q;
    assign hc.state_stall = (state == STALL);

endmodule
